wb_rr_arbiter: RTL and testbench

Round-robin Wishbone arbiter that lets four bus masters share one Wishbone slave port. It sits between the masters (LM32 instruction/data ports, future DMA or debug masters) and a single slave, for example the block RAM or the conbus slave side. It holds a grant for a master's whole `cyc` cycle. An optional watchdog terminates stalled slave accesses with `err`, so one hung peripheral cannot lock the CPU.

---
 rtl/wb_arb_pkg.sv | 22 ++
 rtl/rr_pick.sv | 28 ++
 rtl/wb_rr_arbiter.sv | 147 ++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the round-robin Wishbone arbiter: FSM encoding,
// master count and the one-hot to index helper.
package wb_arb_pkg;

    localparam int ARB_NMASTERS = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_ERR   = 2'd2
    } arb_state_e;

    function automatic logic [1:0] onehot_to_idx(input logic [ARB_NMASTERS-1:0] onehot);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < ARB_NMASTERS; i++) begin
            if (onehot[i]) idx = idx | 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first requester after the pointer wins,
// the pointer's own master is considered last.
module rr_pick
    import wb_arb_pkg::*;
(
    input  logic [ARB_NMASTERS-1:0] i_req,
    input  logic [1:0]              i_ptr,
    output logic [ARB_NMASTERS-1:0] o_grant,
    output logic                    o_valid
);

    logic [1:0] w_idx;

    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        w_idx   = '0;
        // k = 4 wraps to the pointer itself, giving it lowest priority
        for (int k = 1; k <= ARB_NMASTERS; k++) begin
            w_idx = i_ptr + 2'(k);
            if (!o_valid && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                o_valid        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Four-master round-robin Wishbone arbiter holding the grant for a whole cyc.
// Define WB_ARB_TIMEOUT_EN to build the stalled-slave watchdog and ERR state.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int adr_w   = 32,
    parameter int dat_w   = 32,
    parameter int timeout = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [ARB_NMASTERS-1:0]         m_cyc_i,
    input  logic [ARB_NMASTERS-1:0]         m_stb_i,
    input  logic [ARB_NMASTERS-1:0]         m_we_i,
    input  logic [ARB_NMASTERS*adr_w-1:0]   m_adr_i,
    input  logic [ARB_NMASTERS*dat_w-1:0]   m_dat_i,
    input  logic [ARB_NMASTERS*dat_w/8-1:0] m_sel_i,
    output logic [dat_w-1:0]                m_dat_o,
    output logic [ARB_NMASTERS-1:0]         m_ack_o,
    output logic [ARB_NMASTERS-1:0]         m_err_o,
    output logic                            s_cyc_o,
    output logic                            s_stb_o,
    output logic                            s_we_o,
    output logic [adr_w-1:0]                s_adr_o,
    output logic [dat_w-1:0]                s_dat_o,
    output logic [dat_w/8-1:0]              s_sel_o,
    input  logic [dat_w-1:0]                s_dat_i,
    input  logic                            s_ack_i,
    output logic [ARB_NMASTERS-1:0]         grant_o
);

    localparam int SEL_W = dat_w / 8;

    // Handshake: a beat completes in any cycle where cyc and stb are high and the
    // slave returns ack; the master may hold cyc over several beats and owns the
    // slave until it drops cyc. err replaces ack for a beat the watchdog aborts.

    arb_state_e              r_state;
    logic [ARB_NMASTERS-1:0] r_grant;
    logic [1:0]              r_ptr;

    logic [1:0]              w_gidx;
    logic                    w_own_cyc;
    logic [ARB_NMASTERS-1:0] w_pick_grant;
    logic                    w_pick_valid;

    assign w_gidx    = onehot_to_idx(r_grant);
    assign w_own_cyc = m_cyc_i[w_gidx];
    assign grant_o   = r_grant;
    assign m_dat_o   = s_dat_i;

    rr_pick u_pick (
        .i_req   (m_cyc_i),
        .i_ptr   (r_ptr),
        .o_grant (w_pick_grant),
        .o_valid (w_pick_valid)
    );

    // Slave side is a live mux of the owner; everything is forced low otherwise.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        m_ack_o = '0;
        if (r_state == ARB_GRANT) begin
            s_cyc_o = m_cyc_i[w_gidx];
            s_stb_o = m_stb_i[w_gidx];
            s_we_o  = m_we_i[w_gidx];
            s_adr_o = m_adr_i[int'(w_gidx)*adr_w +: adr_w];
            s_dat_o = m_dat_i[int'(w_gidx)*dat_w +: dat_w];
            s_sel_o = m_sel_i[int'(w_gidx)*SEL_W +: SEL_W];
            m_ack_o = r_grant & {ARB_NMASTERS{s_ack_i}};
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(timeout + 1);
    // Reaching this value on a stalled cycle lands the counter on timeout in ERR.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(timeout - 1);

    logic [WD_W-1:0] r_wdog;
    logic            w_stall;

    assign w_stall = s_stb_o & ~s_ack_i;
    assign m_err_o = (r_state == ARB_ERR) ? r_grant : '0;
`else
    assign m_err_o = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ARB_IDLE;
            r_grant <= '0;
            r_ptr   <= 2'd3;
`ifdef WB_ARB_TIMEOUT_EN
            r_wdog  <= '0;
`endif
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_pick_valid) begin
                        r_grant <= w_pick_grant;
                        r_state <= ARB_GRANT;
`ifdef WB_ARB_TIMEOUT_EN
                        r_wdog  <= '0;
`endif
                    end
                end
                ARB_GRANT: begin
                    if (!w_own_cyc) begin
                        r_ptr   <= w_gidx;
                        r_grant <= '0;
                        r_state <= ARB_IDLE;
                    end
`ifdef WB_ARB_TIMEOUT_EN
                    else if (s_ack_i) begin
                        r_wdog <= '0;
                    end else if (w_stall) begin
                        r_wdog <= r_wdog + 1'b1;
                        if (r_wdog == WD_LAST) r_state <= ARB_ERR;
                    end
`endif
                end
`ifdef WB_ARB_TIMEOUT_EN
                ARB_ERR: begin
                    r_wdog <= '0;
                    if (w_own_cyc) begin
                        r_state <= ARB_GRANT;
                    end else begin
                        r_ptr   <= w_gidx;
                        r_grant <= '0;
                        r_state <= ARB_IDLE;
                    end
                end
`endif
                default: begin
                    r_grant <= '0;
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed, table-driven bench for wb_rr_arbiter (timeout section follows
// WB_ARB_TIMEOUT_EN, with timeout = 4).
module tb_wb_rr_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 4;
    localparam logic [2:0] NONE = 3'd4;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      m_cyc_i, m_stb_i, m_we_i;
    logic [4*AW-1:0] m_adr_i;
    logic [4*DW-1:0] m_dat_i;
    logic [4*SW-1:0] m_sel_i;
    logic [DW-1:0]   m_dat_o;
    logic [3:0]      m_ack_o, m_err_o, grant_o;
    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [SW-1:0]   s_sel_o;
    logic [DW-1:0]   s_dat_i;
    logic            s_ack_i;

    int n_checks = 0;
    int n_errors = 0;

    logic [AW-1:0] adr_tab [4] = '{32'h0000_1000, 32'h0000_2004, 32'h0000_0040, 32'hFFFF_FFFC};
    logic [DW-1:0] dat_tab [4] = '{32'hA0A0_0000, 32'hB1B1_1111, 32'hC2C2_2222, 32'hD3D3_3333};
    logic [SW-1:0] sel_tab [4] = '{4'h1, 4'h3, 4'hF, 4'h8};
    logic          we_tab  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    typedef struct packed {
        logic       rst_n;
        logic [3:0] cyc;
        logic       ack;
        logic [3:0] exp_grant;
        logic [2:0] exp_own;
        logic [3:0] exp_ack;
        logic [3:0] exp_err;
    } vec_t;

    vec_t vecs[$];

    wb_rr_arbiter #(.adr_w(AW), .dat_w(DW), .timeout(TMO)) dut (
        .clk(clk), .rst(rst),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .grant_o(grant_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] c, input logic a, input logic [3:0] g,
                       input logic [2:0] o, input logic [3:0] ak, input logic [3:0] er);
        vec_t v;
        v.rst_n = r; v.cyc = c; v.ack = a; v.exp_grant = g;
        v.exp_own = o; v.exp_ack = ak; v.exp_err = er;
        vecs.push_back(v);
    endtask

    // One cycle: drive just after the edge, compare mid-cycle, advance to the next edge.
    task automatic apply_vec(input vec_t v);
        logic          e_cyc, e_we;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_dat;
        logic [SW-1:0] e_sel;
        rst     = v.rst_n;
        m_cyc_i = v.cyc;
        m_stb_i = v.cyc;
        s_ack_i = v.ack;
        s_dat_i = $urandom;
        #2;
        if (v.exp_own == NONE) begin
            e_cyc = 1'b0; e_we = 1'b0; e_adr = '0; e_dat = '0; e_sel = '0;
        end else begin
            e_cyc = v.cyc[v.exp_own[1:0]];
            e_we  = we_tab[v.exp_own[1:0]];
            e_adr = adr_tab[v.exp_own[1:0]];
            e_dat = dat_tab[v.exp_own[1:0]];
            e_sel = sel_tab[v.exp_own[1:0]];
        end
        chk("grant_o", 32'(grant_o), 32'(v.exp_grant));
        chk("m_ack_o", 32'(m_ack_o), 32'(v.exp_ack));
        chk("m_err_o", 32'(m_err_o), 32'(v.exp_err));
        chk("s_cyc_o", 32'(s_cyc_o), 32'(e_cyc));
        chk("s_stb_o", 32'(s_stb_o), 32'(e_cyc));
        chk("s_we_o",  32'(s_we_o),  32'(e_we));
        chk("s_adr_o", s_adr_o, e_adr);
        chk("s_dat_o", s_dat_o, e_dat);
        chk("s_sel_o", 32'(s_sel_o), 32'(e_sel));
        chk("m_dat_o", m_dat_o, s_dat_i);
        @(posedge clk);
        #1;
    endtask

    task automatic mk_apply(input logic r, input logic [3:0] c, input logic a, input logic [3:0] g,
                            input logic [2:0] o, input logic [3:0] ak, input logic [3:0] er);
        vec_t v;
        v.rst_n = r; v.cyc = c; v.ack = a; v.exp_grant = g;
        v.exp_own = o; v.exp_ack = ak; v.exp_err = er;
        apply_vec(v);
    endtask

    initial begin
        rst     = 1'b0;
        m_cyc_i = '0;
        m_stb_i = '0;
        s_ack_i = 1'b0;
        s_dat_i = '0;
        m_we_i  = {we_tab[3], we_tab[2], we_tab[1], we_tab[0]};
        m_adr_i = {adr_tab[3], adr_tab[2], adr_tab[1], adr_tab[0]};
        m_dat_i = {dat_tab[3], dat_tab[2], dat_tab[1], dat_tab[0]};
        m_sel_i = {sel_tab[3], sel_tab[2], sel_tab[1], sel_tab[0]};

        // Reset state
        add(0, 4'b0000, 0, 4'b0000, NONE, 4'b0000, 4'b0000);
        add(0, 4'b0000, 0, 4'b0000, NONE, 4'b0000, 4'b0000);
        // Single request from master 2, ack on the third granted cycle
        add(1, 4'b0000, 0, 4'b0000, NONE, 4'b0000, 4'b0000);
        add(1, 4'b0100, 0, 4'b0000, NONE, 4'b0000, 4'b0000);
        add(1, 4'b0100, 0, 4'b0100, 3'd2, 4'b0000, 4'b0000);
        add(1, 4'b0100, 0, 4'b0100, 3'd2, 4'b0000, 4'b0000);
        add(1, 4'b0100, 1, 4'b0100, 3'd2, 4'b0100, 4'b0000);
        add(1, 4'b0000, 0, 4'b0100, 3'd2, 4'b0000, 4'b0000);
        add(1, 4'b0000, 0, 4'b0000, NONE, 4'b0000, 4'b0000);
        // Fairness from a fresh reset: 0,1,2,3,0 with one idle cycle between owners
        add(0, 4'b0000, 0, 4'b0000, NONE, 4'b0000, 4'b0000);
        add(1, 4'b1111, 0, 4'b0000, NONE, 4'b0000, 4'b0000);
        add(1, 4'b1111, 1, 4'b0001, 3'd0, 4'b0001, 4'b0000);
        add(1, 4'b1110, 0, 4'b0001, 3'd0, 4'b0000, 4'b0000);
        add(1, 4'b1111, 0, 4'b0000, NONE, 4'b0000, 4'b0000);
        add(1, 4'b1111, 1, 4'b0010, 3'd1, 4'b0010, 4'b0000);
        add(1, 4'b1101, 0, 4'b0010, 3'd1, 4'b0000, 4'b0000);
        add(1, 4'b1111, 0, 4'b0000, NONE, 4'b0000, 4'b0000);
        add(1, 4'b1111, 1, 4'b0100, 3'd2, 4'b0100, 4'b0000);
        add(1, 4'b1011, 0, 4'b0100, 3'd2, 4'b0000, 4'b0000);
        add(1, 4'b1111, 0, 4'b0000, NONE, 4'b0000, 4'b0000);
        add(1, 4'b1111, 1, 4'b1000, 3'd3, 4'b1000, 4'b0000);
        add(1, 4'b0111, 0, 4'b1000, 3'd3, 4'b0000, 4'b0000);
        add(1, 4'b1111, 0, 4'b0000, NONE, 4'b0000, 4'b0000);
        add(1, 4'b1111, 1, 4'b0001, 3'd0, 4'b0001, 4'b0000);
        add(1, 4'b1110, 0, 4'b0001, 3'd0, 4'b0000, 4'b0000);
        add(1, 4'b0000, 0, 4'b0000, NONE, 4'b0000, 4'b0000);
        // Burst hold: master 1 keeps the grant for 4 beats while master 0 waits
        add(1, 4'b0011, 0, 4'b0000, NONE, 4'b0000, 4'b0000);
        for (int i = 0; i < 4; i++) add(1, 4'b0011, 1, 4'b0010, 3'd1, 4'b0010, 4'b0000);
        add(1, 4'b0001, 0, 4'b0010, 3'd1, 4'b0000, 4'b0000);
        add(1, 4'b0001, 0, 4'b0000, NONE, 4'b0000, 4'b0000);
        add(1, 4'b0001, 1, 4'b0001, 3'd0, 4'b0001, 4'b0000);
        add(1, 4'b0000, 0, 4'b0001, 3'd0, 4'b0000, 4'b0000);
        add(1, 4'b0000, 0, 4'b0000, NONE, 4'b0000, 4'b0000);
        // Reset mid-transfer drops outputs at once; afterwards 0 beats 3
        add(1, 4'b0001, 0, 4'b0000, NONE, 4'b0000, 4'b0000);
        add(1, 4'b0001, 1, 4'b0001, 3'd0, 4'b0001, 4'b0000);
        add(0, 4'b0001, 1, 4'b0000, NONE, 4'b0000, 4'b0000);
        add(1, 4'b1001, 0, 4'b0000, NONE, 4'b0000, 4'b0000);
        add(1, 4'b1001, 1, 4'b0001, 3'd0, 4'b0001, 4'b0000);
        add(1, 4'b1000, 0, 4'b0001, 3'd0, 4'b0000, 4'b0000);
        add(1, 4'b1000, 0, 4'b0000, NONE, 4'b0000, 4'b0000);
        add(1, 4'b1000, 1, 4'b1000, 3'd3, 4'b1000, 4'b0000);
        add(1, 4'b0000, 0, 4'b1000, 3'd3, 4'b0000, 4'b0000);
        add(1, 4'b0000, 0, 4'b0000, NONE, 4'b0000, 4'b0000);

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i]);

`ifdef WB_ARB_TIMEOUT_EN
        // Stalled slave: err on the 5th stalled cycle, late ack ignored, grant resumes
        mk_apply(1, 4'b1000, 0, 4'b0000, NONE, 4'b0000, 4'b0000);
        for (int i = 0; i < TMO; i++) mk_apply(1, 4'b1000, 0, 4'b1000, 3'd3, 4'b0000, 4'b0000);
        mk_apply(1, 4'b1000, 1, 4'b1000, NONE, 4'b0000, 4'b1000);
        mk_apply(1, 4'b1000, 1, 4'b1000, 3'd3, 4'b1000, 4'b0000);
        mk_apply(1, 4'b0000, 0, 4'b1000, 3'd3, 4'b0000, 4'b0000);
        mk_apply(1, 4'b0000, 0, 4'b0000, NONE, 4'b0000, 4'b0000);
`else
        // Stalled slave with no watchdog: grant and stb held for 100 cycles
        mk_apply(1, 4'b1000, 0, 4'b0000, NONE, 4'b0000, 4'b0000);
        for (int i = 0; i < 100; i++) mk_apply(1, 4'b1000, 0, 4'b1000, 3'd3, 4'b0000, 4'b0000);
        mk_apply(1, 4'b0000, 0, 4'b1000, 3'd3, 4'b0000, 4'b0000);
        mk_apply(1, 4'b0000, 0, 4'b0000, NONE, 4'b0000, 4'b0000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
